// File: rtl/filter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_ctrl_pkg
// Purpose  : Shared state encoding and filter-select codes for the filter
//            switch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package filter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    localparam logic [1:0] FILT_BYPASS = 2'b00;
    localparam logic [1:0] FILT_LOW    = 2'b01;
    localparam logic [1:0] FILT_HIGH   = 2'b10;
    localparam logic [1:0] FILT_BAND   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/sample_tick_sync.sv
`default_nettype none
// ============================================================================
// Module   : sample_tick_sync
// Purpose  : Brings the codec LR clock into the system clock domain and turns
//            each rising edge into a single-cycle sample tick.
// Revision : 1.0 - initial release
// ============================================================================
module sample_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lrck,
    output logic o_tick
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_lrck;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_tick = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/filter_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : filter_switch_ctrl
// Purpose  : Click-free filter select sequencer: fade to zero, change select,
//            fade back up. Optional build macro FILTER_FLUSH_EN holds a
//            filter-bank flush pulse across a multi-sample SWITCH stay.
// Revision : 1.0 - initial release
// ============================================================================
module filter_switch_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int DW        = 32,
    parameter int RAMP_LOG2 = 6,
    parameter int FLUSH_SMP = 4
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          AUD_DACLRCK,
    input  logic [1:0]    filter_req,
    input  logic [DW-1:0] left_in,
    input  logic [DW-1:0] right_in,
    output logic [1:0]    filter_choice,
    output logic [DW-1:0] left_out,
    output logic [DW-1:0] right_out,
    output logic          busy,
    output logic          filter_reset
);

    localparam int c_pw = DW + RAMP_LOG2 + 2;
    localparam logic [RAMP_LOG2:0] c_gain_full = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic [RAMP_LOG2:0] c_gain_one  = {{RAMP_LOG2{1'b0}}, 1'b1};
    localparam logic [RAMP_LOG2:0] c_gain_near = c_gain_full - c_gain_one;

    logic               w_tick;
    state_t             r_state;
    logic [1:0]         r_choice;
    logic [1:0]         r_pending;
    logic [RAMP_LOG2:0] r_gain;
    logic [DW-1:0]      r_left_out;
    logic [DW-1:0]      r_right_out;

    sample_tick_sync u_tick (
        .clk    (CLOCK_50),
        .rst_n  (reset_n),
        .i_lrck (AUD_DACLRCK),
        .o_tick (w_tick)
    );

`ifdef FILTER_FLUSH_EN
    localparam int c_fcw = (FLUSH_SMP > 1) ? $clog2(FLUSH_SMP) : 1;
    localparam logic [c_fcw-1:0] c_flush_last = c_fcw'(FLUSH_SMP - 1);
    localparam logic [c_fcw-1:0] c_flush_one  = c_fcw'(1);

    logic [c_fcw-1:0] r_flush_cnt;
    logic             r_filter_reset;
`else
    logic w_unused_flush;
    assign w_unused_flush = (FLUSH_SMP != 0);
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_choice  <= FILT_BYPASS;
            r_pending <= FILT_BYPASS;
            r_gain    <= c_gain_full;
`ifdef FILTER_FLUSH_EN
            r_flush_cnt    <= '0;
            r_filter_reset <= 1'b0;
`endif
        end else if (w_tick) begin
            r_pending <= filter_req;
            case (r_state)
                IDLE: begin
                    if (r_pending != r_choice)
                        r_state <= FADE_OUT;
                end
                FADE_OUT: begin
                    if (r_pending == r_choice) begin
                        r_state <= FADE_IN;
                    end else if (r_gain <= c_gain_one) begin
                        // Also covers a reversal that arrives already at zero gain
                        r_gain  <= '0;
                        r_state <= SWITCH;
`ifdef FILTER_FLUSH_EN
                        r_choice       <= r_pending;
                        r_filter_reset <= 1'b1;
                        r_flush_cnt    <= '0;
`endif
                    end else begin
                        r_gain <= r_gain - c_gain_one;
                    end
                end
                SWITCH: begin
`ifdef FILTER_FLUSH_EN
                    if (r_flush_cnt == c_flush_last) begin
                        r_filter_reset <= 1'b0;
                        r_state        <= FADE_IN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + c_flush_one;
                    end
`else
                    r_choice <= r_pending;
                    r_state  <= FADE_IN;
`endif
                end
                FADE_IN: begin
                    if (r_pending != r_choice) begin
                        r_state <= FADE_OUT;
                    end else if (r_gain >= c_gain_near) begin
                        // Saturate: an abort right after IDLE re-enters here at full gain
                        r_gain  <= c_gain_full;
                        r_state <= IDLE;
                    end else begin
                        r_gain <= r_gain + c_gain_one;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Full-width signed product; the DW-bit slice above the fraction bits is
    // the arithmetic right shift truncated to DW.
    logic signed [c_pw-1:0] w_gain_ext;
    logic signed [c_pw-1:0] w_left_ext;
    logic signed [c_pw-1:0] w_right_ext;
    logic signed [c_pw-1:0] w_left_prod;
    logic signed [c_pw-1:0] w_right_prod;
    logic                   w_unused_prod;

    assign w_gain_ext   = $signed({{(c_pw-RAMP_LOG2-1){1'b0}}, r_gain});
    assign w_left_ext   = $signed({{(c_pw-DW){left_in[DW-1]}}, left_in});
    assign w_right_ext  = $signed({{(c_pw-DW){right_in[DW-1]}}, right_in});
    assign w_left_prod  = w_left_ext * w_gain_ext;
    assign w_right_prod = w_right_ext * w_gain_ext;
    assign w_unused_prod = ^{w_left_prod[c_pw-1:DW+RAMP_LOG2], w_left_prod[RAMP_LOG2-1:0],
                             w_right_prod[c_pw-1:DW+RAMP_LOG2], w_right_prod[RAMP_LOG2-1:0]};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_left_out  <= '0;
            r_right_out <= '0;
        end else begin
            r_left_out  <= w_left_prod[DW+RAMP_LOG2-1:RAMP_LOG2];
            r_right_out <= w_right_prod[DW+RAMP_LOG2-1:RAMP_LOG2];
        end
    end

    assign filter_choice = r_choice;
    assign left_out      = r_left_out;
    assign right_out     = r_right_out;
    assign busy          = (r_state != IDLE);
`ifdef FILTER_FLUSH_EN
    assign filter_reset  = r_filter_reset;
`else
    assign filter_reset  = 1'b0;
`endif

endmodule
`default_nettype wire
